// File: rtl/pool_feature_buffer.sv
// Ping-pong buffer for pooled feature rows.
// Rows are written into a bank until every entry has been seen. The bank is
// then marked full and streamed out one word at a time while the other bank
// fills. Rows that arrive when no bank is free are dropped and flagged.
module pool_feature_buffer #(
  parameter int WORD_W = 32,
  parameter int N_FEAT = 3,
  parameter int N_ROW  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [1:0]                in_feature_idx,
  input  logic [1:0]                in_row,
  input  logic [N_ROW*WORD_W-1:0]   in_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WORD_W-1:0]         out_data,
  output logic                      out_last,
  output logic                      overflow_err,
  output logic                      index_err
);

  localparam int N_ENT   = N_FEAT * N_ROW;
  localparam int N_WORDS = N_ENT * N_ROW;
  localparam int AW      = (N_ENT > 1) ? $clog2(N_ENT) : 1;
  localparam int CW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int ROW_W   = N_ROW * WORD_W;

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0][N_ENT-1:0]   mask_q, mask_d;
  logic [1:0]              full_q, full_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic                    overflow_err_q, overflow_err_d;
  logic                    index_err_q, index_err_d;

  // Storage is deliberately left out of reset.
  logic [ROW_W-1:0]        mem_q [2][N_ENT];

  logic                    idx_legal;
  logic [AW-1:0]           wr_addr;
  logic                    wr_en;
  logic [N_ENT-1:0]        new_mask;
  logic                    last_word;
  logic [AW-1:0]           rd_ent;
  int                      rd_word;
  logic [ROW_W-1:0]        rd_row;

  assign idx_legal = (int'(in_feature_idx) < N_FEAT) && (int'(in_row) < N_ROW);
  assign wr_addr   = AW'(int'(in_feature_idx) * N_ROW + int'(in_row));
  assign last_word = (cnt_q == CW'(N_WORDS - 1));

  // Write-side bookkeeping plus the read FSM next state; both touch full_d,
  // but always on different banks since a bank being read is never written.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mask_d         = mask_q;
    full_d         = full_q;
    wr_bank_d      = wr_bank_q;
    rd_bank_d      = rd_bank_q;
    overflow_err_d = overflow_err_q;
    index_err_d    = index_err_q;
    wr_en          = 1'b0;
    new_mask       = mask_q[wr_bank_q] | (N_ENT'(1) << wr_addr);

    if (in_valid) begin
      if (!idx_legal) begin
        index_err_d = 1'b1;
      end else if (full_q[wr_bank_q]) begin
        overflow_err_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (&new_mask) begin
          full_d[wr_bank_q] = 1'b1;
          mask_d[wr_bank_q] = '0;
          wr_bank_d         = ~wr_bank_q;
        end else begin
          mask_d[wr_bank_q] = new_mask;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (last_word) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            state_d           = IDLE;
            cnt_d             = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mask_q         <= '0;
      full_q         <= '0;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      overflow_err_q <= 1'b0;
      index_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mask_q         <= mask_d;
      full_q         <= full_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      overflow_err_q <= overflow_err_d;
      index_err_q    <= index_err_d;
    end
  end

  // Row storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_bank_q][wr_addr] <= in_data;
  end

  // Read word select: entry cnt/N_ROW, word cnt%N_ROW with word 0 in the MSBs.
  always_comb begin
    rd_ent   = AW'(int'(cnt_q) / N_ROW);
    rd_word  = int'(cnt_q) % N_ROW;
    rd_row   = mem_q[rd_bank_q][rd_ent];
    out_data = rd_row[(N_ROW - 1 - rd_word) * WORD_W +: WORD_W];
  end

  assign out_valid    = (state_q == STREAM);
  assign out_last     = out_valid && last_word;
  assign overflow_err = overflow_err_q;
  assign index_err    = index_err_q;

endmodule

// File: tb/tb_pool_feature_buffer.sv
// Directed bench for pool_feature_buffer at default parameters.
module tb_pool_feature_buffer;

  localparam int WORD_W  = 32;
  localparam int N_FEAT  = 3;
  localparam int N_ROW   = 3;
  localparam int N_WORDS = N_FEAT * N_ROW * N_ROW;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic [1:0]              in_feature_idx = '0;
  logic [1:0]              in_row = '0;
  logic [N_ROW*WORD_W-1:0] in_data = '0;
  logic                    out_ready = 1'b0;
  logic                    out_valid;
  logic [WORD_W-1:0]       out_data;
  logic                    out_last;
  logic                    overflow_err;
  logic                    index_err;

  int n_vec = 0;
  int n_err = 0;

  pool_feature_buffer #(.WORD_W(WORD_W), .N_FEAT(N_FEAT), .N_ROW(N_ROW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_feature_idx (in_feature_idx),
    .in_row         (in_row),
    .in_data        (in_data),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .overflow_err   (overflow_err),
    .index_err      (index_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [N_ROW*WORD_W-1:0] mk_row(input int base, input int idx, input int row);
    int v;
    v = base + idx * 9 + row * 3;
    return {32'(v), 32'(v + 1), 32'(v + 2)};
  endfunction

  task automatic write_row(input int idx, input int row, input logic [N_ROW*WORD_W-1:0] d);
    @(negedge clk);
    in_valid       = 1'b1;
    in_feature_idx = 2'(idx);
    in_row         = 2'(row);
    in_data        = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic fill_image(input int base);
    for (int i = 0; i < N_FEAT; i++)
      for (int r = 0; r < N_ROW; r++)
        write_row(i, r, mk_row(base, i, r));
  endtask

  // Consumes nwords handshakes; every valid cycle (stalled or not) must show
  // word base+k, and out_last only on the final word of the image.
  task automatic stream_check(input string tag, input bit toggle, input int nwords, input int base);
    int k;
    int cyc;
    bit rdy;
    k = 0;
    cyc = 0;
    rdy = 1'b1;
    while (k < nwords && cyc < 500) begin
      @(negedge clk);
      out_ready = toggle ? rdy : 1'b1;
      rdy = ~rdy;
      #1;
      if (out_valid) begin
        check({tag, " data"}, 64'(out_data), 64'(base + k));
        check({tag, " last"}, 64'(out_last), 64'(k == N_WORDS - 1));
        if (out_ready) k++;
      end
      cyc++;
    end
    check({tag, " count"}, 64'(k), 64'(nwords));
  endtask

  task automatic gap_check(input string tag);
    @(negedge clk);
    #1;
    check({tag, " gap"}, 64'(out_valid), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst out_last", 64'(out_last), 64'(0));
    check("rst overflow", 64'(overflow_err), 64'(0));
    check("rst index", 64'(index_err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Forward-order fill, free-running sink.
    fill_image(0);
    stream_check("fwd", 1'b0, N_WORDS, 0);
    gap_check("fwd");
    check("fwd overflow", 64'(overflow_err), 64'(0));
    check("fwd index", 64'(index_err), 64'(0));

    // Reverse-order fill; (1,1) first gets junk then the real row.
    write_row(1, 1, mk_row(999, 0, 0));
    for (int i = N_FEAT - 1; i >= 0; i--)
      for (int r = N_ROW - 1; r >= 0; r--)
        write_row(i, r, mk_row(100, i, r));
    stream_check("rev", 1'b0, N_WORDS, 100);
    gap_check("rev");
    check("rev overflow", 64'(overflow_err), 64'(0));

    // Sink alternating ready/not-ready.
    fill_image(200);
    stream_check("tog", 1'b1, N_WORDS, 200);
    gap_check("tog");

    // Stalled sink: two images buffered, third dropped.
    @(negedge clk);
    out_ready = 1'b0;
    fill_image(300);
    fill_image(400);
    fill_image(500);
    #1;
    check("ovf flag", 64'(overflow_err), 64'(1));
    check("ovf index", 64'(index_err), 64'(0));
    check("ovf held valid", 64'(out_valid), 64'(1));
    check("ovf held data", 64'(out_data), 64'(300));
    stream_check("ovf img1", 1'b0, N_WORDS, 300);
    gap_check("ovf img1");
    stream_check("ovf img2", 1'b0, N_WORDS, 400);
    gap_check("ovf img2");
    repeat (10) @(negedge clk);
    #1;
    check("ovf no img3", 64'(out_valid), 64'(0));

    // Illegal index/row must not touch the mask.
    do_reset();
    #1;
    check("idx rst overflow", 64'(overflow_err), 64'(0));
    write_row(3, 0, mk_row(900, 0, 0));
    write_row(0, 3, mk_row(900, 0, 0));
    #1;
    check("idx flag", 64'(index_err), 64'(1));
    check("idx overflow", 64'(overflow_err), 64'(0));
    for (int i = 0; i < N_FEAT; i++)
      for (int r = 0; r < N_ROW; r++)
        if (!(i == 1 && r == 0)) write_row(i, r, mk_row(600, i, r));
    repeat (10) @(negedge clk);
    #1;
    check("idx no stream", 64'(out_valid), 64'(0));
    write_row(1, 0, mk_row(600, 1, 0));
    stream_check("idx img", 1'b0, N_WORDS, 600);
    gap_check("idx img");

    // Reset in the middle of a stream.
    fill_image(700);
    stream_check("abort", 1'b0, 10, 700);
    @(negedge clk);
    #1;
    check("abort pre data", 64'(out_data), 64'(710));
    rst_n = 1'b0;
    #1;
    check("abort valid", 64'(out_valid), 64'(0));
    check("abort last", 64'(out_last), 64'(0));
    check("abort index", 64'(index_err), 64'(0));
    check("abort overflow", 64'(overflow_err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("abort quiet", 64'(out_valid), 64'(0));
    fill_image(800);
    stream_check("post", 1'b0, N_WORDS, 800);
    gap_check("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
